// File: rtl/axis_rd_pkg.sv
// Shared types and helpers for the frame reader and its writer-side siblings.
// Holds the control state encoding and a width-generic tkeep lane counter.
package axis_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PASS,
      TRUNC,
      GAP,
      PAUSED
   } rd_state_t;

   // Widest tkeep the shared counter handles; callers zero-extend into it.
   localparam int MAX_KEEP = 128;
   localparam int POP_W    = 8;

   function automatic logic [POP_W-1:0] keep_popcount(
      input logic [MAX_KEEP-1:0] keep,
      input int                  keep_width
   );
      logic [POP_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_KEEP; i++) begin
         if (i < keep_width && keep[i]) begin
            cnt = cnt + POP_W'(1);
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational count of asserted tkeep lanes.
// Shared with the writer-side blocks so byte accounting matches on both ends.
module axis_keep_popcount
   import axis_rd_pkg::*;
#(
   parameter int KEEP_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(KEEP_WIDTH + 1)
) (
   input  logic [KEEP_WIDTH-1:0] i_keep,
   output logic [CNT_WIDTH-1:0]  o_count
);

   logic [MAX_KEEP-1:0] w_keep_ext;
   logic [POP_W-1:0]    w_count_full;

   assign w_keep_ext   = MAX_KEEP'(i_keep);
   assign w_count_full = keep_popcount(w_keep_ext, KEEP_WIDTH);
   assign o_count      = w_count_full[CNT_WIDTH-1:0];

endmodule

// File: rtl/axis_frame_reader.sv
// Drains whole frames from the FIFO through a one-deep output register,
// truncating oversize frames, enforcing an inter-frame gap and a pause handshake.
module axis_frame_reader
   import axis_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int LEN_WIDTH  = 16,
   parameter int MAX_LEN    = 1536,
   parameter int IFG_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   input  logic                  cfg_pause,
   output logic                  pause_req,
   input  logic                  pause_ack,
   output logic                  paused,
   output logic [LEN_WIDTH-1:0]  frame_len,
   output logic                  frame_len_valid,
   output logic                  frame_bad,
   output logic [31:0]           stat_frames,
   output logic [31:0]           stat_oversize
);

   localparam int CNT_WIDTH = $clog2(KEEP_WIDTH + 1);
   localparam int GAP_WIDTH = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [LEN_WIDTH:0]   MAX_LEN_C  = (LEN_WIDTH + 1)'(MAX_LEN);
   localparam logic [LEN_WIDTH:0]   LEN_SAT_C  = {1'b0, {LEN_WIDTH{1'b1}}};
   localparam logic [GAP_WIDTH-1:0] GAP_LAST_C = GAP_WIDTH'(IFG_CYCLES - 1);
   localparam rd_state_t            AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

   rd_state_t             r_state;
   rd_state_t             w_state_next;
   logic [LEN_WIDTH:0]    r_acc;
   logic                  r_bad;
   logic [GAP_WIDTH-1:0]  r_gap_cnt;

   logic [DATA_WIDTH-1:0] r_tdata;
   logic [KEEP_WIDTH-1:0] r_tkeep;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic [USER_WIDTH-1:0] r_tuser;

   logic [LEN_WIDTH-1:0]  r_frame_len;
   logic                  r_frame_len_valid;
   logic                  r_frame_bad;
   logic [31:0]           r_stat_frames;
   logic [31:0]           r_stat_oversize;

   logic [CNT_WIDTH-1:0]  w_count;
   logic [LEN_WIDTH:0]    w_sum;
   logic [LEN_WIDTH-1:0]  w_len_sat;
   logic                  w_over;
   logic                  w_load;
   logic                  w_fwd_state;
   logic                  w_sready;
   logic                  w_accept;
   logic                  w_emit;
   logic                  w_complete;

   axis_keep_popcount #(
      .KEEP_WIDTH (KEEP_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_popcount (
      .i_keep  (s_axis_tkeep),
      .o_count (w_count)
   );

   assign w_sum     = r_acc + (LEN_WIDTH + 1)'(w_count);
   assign w_over    = (w_sum > MAX_LEN_C);
   assign w_len_sat = (w_sum > LEN_SAT_C) ? LEN_SAT_C[LEN_WIDTH-1:0] : w_sum[LEN_WIDTH-1:0];

   // A pause request seen in IDLE wins over a waiting beat, so nothing slips in.
   assign w_load      = !r_tvalid || m_axis_tready;
   assign w_fwd_state = (r_state == IDLE && !cfg_pause) || (r_state == PASS);
   assign w_sready    = rst_n && ((w_fwd_state && w_load) || (r_state == TRUNC));
   assign w_accept    = s_axis_tvalid && w_sready;
   assign w_emit      = w_accept && w_fwd_state;
   assign w_complete  = w_emit && (s_axis_tlast || w_over);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE, PASS: begin
            if (r_state == IDLE && cfg_pause) begin
               w_state_next = PAUSED;
            end else if (w_complete) begin
               w_state_next = (w_over && !s_axis_tlast) ? TRUNC : AFTER_FRAME;
            end else if (w_emit) begin
               w_state_next = PASS;
            end
         end
         TRUNC: begin
            if (w_accept && s_axis_tlast) begin
               w_state_next = AFTER_FRAME;
            end
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST_C) begin
               w_state_next = IDLE;
            end
         end
         PAUSED: begin
            if (!cfg_pause) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc             <= '0;
         r_bad             <= 1'b0;
         r_gap_cnt         <= '0;
         r_tdata           <= '0;
         r_tkeep           <= '0;
         r_tvalid          <= 1'b0;
         r_tlast           <= 1'b0;
         r_tuser           <= '0;
         r_frame_len       <= '0;
         r_frame_len_valid <= 1'b0;
         r_frame_bad       <= 1'b0;
         r_stat_frames     <= '0;
         r_stat_oversize   <= '0;
      end else begin
         if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_WIDTH'(1);
         end else begin
            r_gap_cnt <= '0;
         end

         if (w_complete) begin
            r_acc <= '0;
            r_bad <= 1'b0;
         end else if (w_emit) begin
            r_acc <= w_sum;
            r_bad <= r_bad | s_axis_tuser[0];
         end

         // Drain and refill share one edge, giving full throughput.
         if (w_load) begin
            r_tvalid <= w_emit;
            if (w_emit) begin
               r_tdata <= s_axis_tdata;
               r_tkeep <= s_axis_tkeep;
               r_tlast <= s_axis_tlast | w_over;
               r_tuser <= s_axis_tuser | USER_WIDTH'(w_over);
            end
         end

         r_frame_len_valid <= w_complete;
         if (w_complete) begin
            r_frame_len   <= w_len_sat;
            r_frame_bad   <= w_over | r_bad | s_axis_tuser[0];
            r_stat_frames <= r_stat_frames + 32'd1;
         end

         if (w_emit && w_over) begin
            r_stat_oversize <= r_stat_oversize + 32'd1;
         end
      end
   end

   assign s_axis_tready   = w_sready;
   assign m_axis_tdata    = r_tdata;
   assign m_axis_tkeep    = r_tkeep;
   assign m_axis_tvalid   = r_tvalid;
   assign m_axis_tlast    = r_tlast;
   assign m_axis_tuser    = r_tuser;
   assign pause_req       = (r_state == PAUSED);
   assign paused          = (r_state == PAUSED) && pause_ack;
   assign frame_len       = r_frame_len;
   assign frame_len_valid = r_frame_len_valid;
   assign frame_bad       = r_frame_bad;
   assign stat_frames     = r_stat_frames;
   assign stat_oversize   = r_stat_oversize;

endmodule

// File: tb/tb_axis_frame_reader.sv
// Directed bench for axis_frame_reader: three instances (default, MAX_LEN=16,
// IFG_CYCLES=0) share one stimulus; each test checks the instance it targets.
module tb_axis_frame_reader;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tvalid;
   logic        s_tlast;
   logic [0:0]  s_tuser;
   logic        m_tready;
   logic        cfg_pause;
   logic        pause_ack;

   logic        s_tready   [3];
   logic [63:0] m_tdata    [3];
   logic [7:0]  m_tkeep    [3];
   logic        m_tvalid   [3];
   logic        m_tlast    [3];
   logic [0:0]  m_tuser    [3];
   logic        pause_req  [3];
   logic        paused     [3];
   logic [15:0] frame_len  [3];
   logic        flv        [3];
   logic        fbad       [3];
   logic [31:0] stat_frm   [3];
   logic [31:0] stat_ovr   [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      axis_frame_reader #(
         .MAX_LEN    ((gi == 1) ? 16 : 1536),
         .IFG_CYCLES ((gi == 2) ? 0 : 3)
      ) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .s_axis_tdata    (s_tdata),
         .s_axis_tkeep    (s_tkeep),
         .s_axis_tvalid   (s_tvalid),
         .s_axis_tready   (s_tready[gi]),
         .s_axis_tlast    (s_tlast),
         .s_axis_tuser    (s_tuser),
         .m_axis_tdata    (m_tdata[gi]),
         .m_axis_tkeep    (m_tkeep[gi]),
         .m_axis_tvalid   (m_tvalid[gi]),
         .m_axis_tready   (m_tready),
         .m_axis_tlast    (m_tlast[gi]),
         .m_axis_tuser    (m_tuser[gi]),
         .cfg_pause       (cfg_pause),
         .pause_req       (pause_req[gi]),
         .pause_ack       (pause_ack),
         .paused          (paused[gi]),
         .frame_len       (frame_len[gi]),
         .frame_len_valid (flv[gi]),
         .frame_bad       (fbad[gi]),
         .stat_frames     (stat_frm[gi]),
         .stat_oversize   (stat_ovr[gi])
      );
   end

   typedef struct {
      logic        rb;
      int          sel;
      logic        v;
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        mr;
      logic        e_sr;
      logic        e_mv;
      logic [63:0] e_md;
      logic [7:0]  e_mk;
      logic        e_ml;
      logic        e_mu;
      logic        e_flv;
      logic [15:0] e_len;
      logic        e_bad;
      logic [31:0] e_sf;
      logic [31:0] e_so;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(
      input logic rb, input int sel, input logic v, input logic [63:0] d,
      input logic [7:0] k, input logic l, input logic mr, input logic e_sr,
      input logic e_mv, input logic [63:0] e_md, input logic [7:0] e_mk,
      input logic e_ml, input logic e_mu, input logic e_flv,
      input logic [15:0] e_len, input logic e_bad,
      input logic [31:0] e_sf, input logic [31:0] e_so);
      vec_t x;
      x.rb = rb; x.sel = sel; x.v = v; x.d = d; x.k = k; x.l = l; x.mr = mr;
      x.e_sr = e_sr; x.e_mv = e_mv; x.e_md = e_md; x.e_mk = e_mk;
      x.e_ml = e_ml; x.e_mu = e_mu; x.e_flv = e_flv; x.e_len = e_len;
      x.e_bad = e_bad; x.e_sf = e_sf; x.e_so = e_so;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      s_tvalid  = 1'b0;
      s_tdata   = '0;
      s_tkeep   = '0;
      s_tlast   = 1'b0;
      s_tuser   = '0;
      m_tready  = 1'b1;
      cfg_pause = 1'b0;
      pause_ack = 1'b0;
   endtask

   // Leaves the bench 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_s_tready", s_tready[d], 0);
         chk("rst_m_tvalid", m_tvalid[d], 0);
         chk("rst_pause_req", pause_req[d], 0);
         chk("rst_paused", paused[d], 0);
         chk("rst_flv", flv[d], 0);
         chk("rst_frame_len", frame_len[d], 0);
         chk("rst_stat_frames", stat_frm[d], 0);
         chk("rst_stat_oversize", stat_ovr[d], 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t x);
      if (x.rb) do_reset();
      s_tvalid = x.v;
      s_tdata  = x.d;
      s_tkeep  = x.k;
      s_tlast  = x.l;
      s_tuser  = '0;
      m_tready = x.mr;
      #1;
      $display("vec %0d dut%0d: v=%0b d=%h k=%h l=%0b mready=%0b sready=%0b",
               idx, x.sel, x.v, x.d, x.k, x.l, x.mr, s_tready[x.sel]);
      chk("s_tready", s_tready[x.sel], x.e_sr);
      @(posedge clk);
      #1;
      chk("m_tvalid", m_tvalid[x.sel], x.e_mv);
      if (x.e_mv) begin
         chk("m_tdata", m_tdata[x.sel], x.e_md);
         chk("m_tkeep", m_tkeep[x.sel], x.e_mk);
         chk("m_tlast", m_tlast[x.sel], x.e_ml);
         chk("m_tuser", m_tuser[x.sel], x.e_mu);
      end
      chk("frame_len_valid", flv[x.sel], x.e_flv);
      if (x.e_flv) begin
         chk("frame_len", frame_len[x.sel], x.e_len);
         chk("frame_bad", fbad[x.sel], x.e_bad);
      end
      chk("stat_frames", stat_frm[x.sel], x.e_sf);
      chk("stat_oversize", stat_ovr[x.sel], x.e_so);
   endtask

   initial begin
      logic [63:0] d0;
      logic [63:0] d1;
      d0 = 64'h0706050403020100;
      d1 = 64'h0000000C0B0A0908;

      // 64-byte frame, 3-cycle gap with a beat waiting, then a 1-byte frame.
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(mkv((i == 0), 0, T, 64'h1000 + 64'(i), 8'hFF, (i == 7), T,
                           T, T, 64'h1000 + 64'(i), 8'hFF, (i == 7), F,
                           (i == 7), 16'd64, F, (i == 7) ? 32'd1 : 32'd0, 32'd0));
      end
      for (int i = 0; i < 3; i++) begin
         tbl.push_back(mkv(F, 0, T, 64'hAAAA, 8'h01, T, T,
                           F, F, 64'h0, 8'h0, F, F, F, 16'd0, F, 32'd1, 32'd0));
      end
      tbl.push_back(mkv(F, 0, T, 64'hAAAA, 8'h01, T, T,
                        T, T, 64'hAAAA, 8'h01, T, F, T, 16'd1, F, 32'd2, 32'd0));

      // 13-byte frame with downstream ready toggling 1010.
      tbl.push_back(mkv(T, 0, T, d0, 8'hFF, F, T, T, T, d0, 8'hFF, F, F, F, 16'd0, F, 32'd0, 32'd0));
      tbl.push_back(mkv(F, 0, T, d1, 8'h1F, T, F, F, T, d0, 8'hFF, F, F, F, 16'd0, F, 32'd0, 32'd0));
      tbl.push_back(mkv(F, 0, T, d1, 8'h1F, T, T, T, T, d1, 8'h1F, T, F, T, 16'd13, F, 32'd1, 32'd0));
      tbl.push_back(mkv(F, 0, F, 64'h0, 8'h00, F, F, F, T, d1, 8'h1F, T, F, F, 16'd0, F, 32'd1, 32'd0));
      tbl.push_back(mkv(F, 0, F, 64'h0, 8'h00, F, T, F, F, 64'h0, 8'h0, F, F, F, 16'd0, F, 32'd1, 32'd0));

      // MAX_LEN=16: 32-byte frame truncated at beat 2, beat 3 discarded.
      tbl.push_back(mkv(T, 1, T, 64'h3000, 8'hFF, F, T, T, T, 64'h3000, 8'hFF, F, F, F, 16'd0, F, 32'd0, 32'd0));
      tbl.push_back(mkv(F, 1, T, 64'h3001, 8'hFF, F, T, T, T, 64'h3001, 8'hFF, F, F, F, 16'd0, F, 32'd0, 32'd0));
      tbl.push_back(mkv(F, 1, T, 64'h3002, 8'hFF, F, T, T, T, 64'h3002, 8'hFF, T, T, T, 16'd24, T, 32'd1, 32'd1));
      tbl.push_back(mkv(F, 1, T, 64'h3003, 8'hFF, T, T, T, F, 64'h0, 8'h0, F, F, F, 16'd0, F, 32'd1, 32'd1));
      tbl.push_back(mkv(F, 1, F, 64'h0, 8'h00, F, T, F, F, 64'h0, 8'h0, F, F, F, 16'd0, F, 32'd1, 32'd1));

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(i, tbl[i]);
      end

      // Pause raised mid-frame takes effect only after the frame and its gap.
      do_reset();
      s_tvalid = 1'b1; s_tdata = 64'h4000; s_tkeep = 8'hFF; s_tlast = 1'b0;
      #1;
      chk("pause_beat0_sready", s_tready[0], 1);
      @(posedge clk); #1;
      cfg_pause = 1'b1;
      s_tdata = 64'h4001; s_tlast = 1'b1;
      #1;
      chk("pause_beat1_sready", s_tready[0], 1);
      chk("pause_req_midframe", pause_req[0], 0);
      @(posedge clk); #1;
      $display("pause: frame done len=%0d", frame_len[0]);
      chk("pause_flv", flv[0], 1);
      chk("pause_len", frame_len[0], 16);
      s_tdata = 64'h4002; s_tkeep = 8'hFF; s_tlast = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("pause_gap_sready", s_tready[0], 0);
         chk("pause_gap_req", pause_req[0], 0);
         @(posedge clk); #1;
      end
      chk("pause_req_rise", pause_req[0], 1);
      chk("paused_no_ack", paused[0], 0);
      chk("paused_sready", s_tready[0], 0);
      pause_ack = 1'b1;
      #1;
      chk("paused_ack", paused[0], 1);
      @(posedge clk); #1;
      chk("paused_hold", paused[0], 1);
      cfg_pause = 1'b0;
      @(posedge clk); #1;
      chk("unpause_req", pause_req[0], 0);
      chk("unpause_paused", paused[0], 0);
      #1;
      chk("unpause_sready", s_tready[0], 1);
      @(posedge clk); #1;
      $display("pause: resumed frame data=%h", m_tdata[0]);
      chk("unpause_mvalid", m_tvalid[0], 1);
      chk("unpause_mdata", m_tdata[0], 64'h4002);
      chk("unpause_flv", flv[0], 1);
      chk("unpause_len", frame_len[0], 8);

      // IFG_CYCLES=0: back-to-back single-beat frames, one per cycle.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         s_tvalid = 1'b1; s_tdata = 64'h50 + 64'(i); s_tkeep = 8'h0F; s_tlast = 1'b1;
         #1;
         chk("b2b_sready", s_tready[2], 1);
         @(posedge clk); #1;
         $display("b2b frame %0d: data=%h frames=%0d", i, m_tdata[2], stat_frm[2]);
         chk("b2b_mdata", m_tdata[2], 64'h50 + 64'(i));
         chk("b2b_flv", flv[2], 1);
         chk("b2b_len", frame_len[2], 4);
         chk("b2b_stat_frames", stat_frm[2], 32'(i + 1));
      end

      // Reset during beat 3 of 8: partial frame vanishes, next frame is clean.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1; s_tdata = 64'h6000 + 64'(i); s_tkeep = 8'hFF; s_tlast = 1'b0;
         @(posedge clk); #1;
      end
      chk("pre_rst_mvalid", m_tvalid[0], 1);
      s_tdata = 64'h6003;
      rst_n = 1'b0;
      #1;
      $display("midframe reset: mvalid=%0b", m_tvalid[0]);
      chk("midrst_mvalid", m_tvalid[0], 0);
      chk("midrst_flv", flv[0], 0);
      @(posedge clk); #1;
      chk("midrst_flv_edge", flv[0], 0);
      chk("midrst_stat", stat_frm[0], 0);
      rst_n = 1'b1;
      s_tvalid = 1'b0;
      @(posedge clk); #1;
      chk("postrst_flv", flv[0], 0);
      s_tvalid = 1'b1; s_tdata = 64'h7000; s_tkeep = 8'hFF; s_tlast = 1'b1;
      #1;
      chk("postrst_sready", s_tready[0], 1);
      @(posedge clk); #1;
      $display("post-reset frame: data=%h len=%0d", m_tdata[0], frame_len[0]);
      chk("postrst_mdata", m_tdata[0], 64'h7000);
      chk("postrst_flv2", flv[0], 1);
      chk("postrst_len", frame_len[0], 8);
      chk("postrst_bad", fbad[0], 0);
      chk("postrst_stat", stat_frm[0], 1);
      s_tvalid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_frame_reader.md
Name: axis_frame_reader

Overview:
Reader end of the width-adapting frame FIFO. Drains whole frames from the FIFO master port and re-emits them downstream through a registered output stage. Enforces a configurable inter-frame gap and a maximum frame length, truncating and marking oversize frames. Drives the FIFO pause handshake and reports per-frame byte length plus running statistics.

Parameters:
DATA_WIDTH, 64, tdata width in bits; must equal 8*KEEP_WIDTH.
KEEP_WIDTH, 8, tkeep width (byte lanes).
USER_WIDTH, 1, tuser width; bit 0 is the bad-frame marker.
LEN_WIDTH, 16, width of byte-length counters and reports.
MAX_LEN, 1536, maximum frame length in bytes; 1 <= MAX_LEN < 2**LEN_WIDTH.
IFG_CYCLES, 3, idle cycles forced after each emitted frame; 0 disables the gap.

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
s_axis_tdata  in  DATA_WIDTH  frame data from FIFO.
s_axis_tkeep  in  KEEP_WIDTH  byte enables; contiguous from lane 0.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tlast  in  1  end of frame.
s_axis_tuser  in  USER_WIDTH  sideband.
m_axis_tdata  out  DATA_WIDTH  output data.
m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  output end of frame.
m_axis_tuser  out  USER_WIDTH  output sideband; bit 0 forced to 1 on truncation.
cfg_pause  in  1  software pause request.
pause_req  out  1  pause request to FIFO.
pause_ack  in  1  FIFO pause acknowledge.
paused  out  1  this block is in PAUSED and pause_ack is high.
frame_len  out  LEN_WIDTH  byte length of the last completed frame.
frame_len_valid  out  1  one-cycle pulse when frame_len updates.
frame_bad  out  1  qualifies frame_len_valid; frame was truncated or had input tuser[0]=1.
stat_frames  out  32  count of frames emitted; wraps.
stat_oversize  out  32  count of frames truncated; wraps.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n is low, all outputs are 0: s_axis_tready, m_axis_tvalid, pause_req, paused, frame_len_valid, frame_len, stat_*, and all state.
- Output stage: a single register. The stage loads when it is empty or m_axis_tready=1. s_axis_tready = state in {IDLE,PASS} && (!m_axis_tvalid || m_axis_tready), or 1 in TRUNC. Latency is 1 cycle input to output, at full throughput. m_axis_* hold stable while valid && !ready.
- Byte count: acc += popcount(tkeep) per accepted beat. Width is LEN_WIDTH+1 internally; the reported value saturates at 2**LEN_WIDTH-1.
- States:
  - IDLE: if cfg_pause=1, go to PAUSED. Else on the first accepted beat go to PASS, or complete the frame if tlast=1.
  - PASS: forward beats unchanged.
  - On an accepted beat where acc+popcount > MAX_LEN:
    - Emit that beat with tlast=1 and tuser[0]=1; increment stat_oversize.
    - Go to TRUNC if the input tlast=0; otherwise complete the frame.
  - TRUNC: s_axis_tready=1 and beats are discarded, nothing emitted. On the accepted tlast, go to GAP (or IDLE if IFG_CYCLES=0). A truncated frame counts exactly once in stat_frames.
  - Frame complete: this is the cycle the final beat loads the output register.
    - Pulse frame_len_valid and set frame_len, including bytes of the over-limit beat.
    - Set frame_bad = truncated | any input tuser[0].
    - Increment stat_frames.
    - Go to GAP (after TRUNC drain if truncating).
  - GAP: s_axis_tready=0 for exactly IFG_CYCLES cycles, counted from the cycle after completion, then go to IDLE. Skipped when IFG_CYCLES=0.
  - PAUSED: pause_req=1, s_axis_tready=0. paused = pause_ack. When cfg_pause=0, deassert pause_req and go to IDLE the next cycle.
- pause_req rises only in PAUSED; cfg_pause mid-frame takes effect only after the frame and its gap finish.
- Simultaneous output drain and new load in the same cycle is legal and required for full throughput.
- rst_n asserted mid-frame: the partial frame is lost with no frame_len_valid pulse; m_axis_tvalid drops immediately (asynchronous clear).

Decomposition:
- Shared package axis_rd_pkg: state enum (IDLE, PASS, TRUNC, GAP, PAUSED) and the keep-popcount function, parameterised by KEEP_WIDTH.
- One sub-module, axis_keep_popcount: combinational lane count, reusable by the writer-side blocks.

Test Plan:
- 64-byte frame, 8 beats all keep=0xFF, m_axis_tready=1 -> 8 output beats at 1-cycle latency, frame_len=64, frame_bad=0, then exactly 3 cycles with s_axis_tready=0.
- 13-byte frame (keep 0xFF then 0x1F), tready toggling 1010 -> data and keep intact and stable while stalled; frame_len=13.
- MAX_LEN=16, 32-byte frame -> beats 0 and 1 emitted, beat 2 (24 bytes cumulative) emitted with tlast=1 and tuser[0]=1, beat 3 discarded; stat_oversize=1, frame_len=24, frame_bad=1.
- cfg_pause raised mid-frame -> frame completes and gap runs, then pause_req=1; with pause_ack=1, paused=1; cfg_pause low -> pause_req=0 and next frame accepted.
- IFG_CYCLES=0, back-to-back 1-beat frames -> one frame per cycle, stat_frames increments every cycle.
- rst_n pulsed low during beat 3 of 8 -> m_axis_tvalid=0 immediately, no frame_len_valid; a subsequent frame is clean.
